result_serial_tx: RTL and testbench
===================================

Name: result_serial_tx

Overview:
- Bit-serial transmitter that sends the processor's final register contents off-chip. It is the output-side counterpart of the switch/push-button loading path.
- On a Send request it snapshots the 8-bit A and B register values. It then transmits them as two UART-style frames on a single line: A first, then B.
- It sits beside the processor top level, fed by the Aval/Bval debug buses and a synchronized, active-high push-button signal.

Parameters:
- CLKS_PER_BIT, 434, Clk cycles per serial bit (50 MHz / 115200 baud); legal range 2..65535.

Ports:
- Clk  input  1  system clock, all logic on rising edge
- Reset  input  1  synchronous, active-low reset; sampled on rising edge of Clk
- Send  input  1  transmit request, already synchronized, active high; rising-edge detected internally
- Aval  input  8  A register value to transmit
- Bval  input  8  B register value to transmit
- Tx  output  1  serial line, idle high
- Busy  output  1  high from the cycle after Send is accepted until the cycle Done pulses
- Done  output  1  one-cycle pulse when the B frame's stop bit completes

Behaviour:
- Reset (Reset=0 at a Clk edge):
  - Tx=1, Busy=0, Done=0, state=IDLE, bit counter=0, baud counter=0.
  - The Send edge detector's previous-value register is cleared to 1, so a button held through reset does not trigger.
- Send edge detection: accept when Send=1 and previous Send=0, in IDLE only. Edges in any other state are ignored and never queued.
- On accept:
  - Latch Aval and Bval into internal shift registers.
  - Set byte_sel=A and enter START.
  - Tx=0 and Busy=1 take effect in the first cycle after the accepting edge (latency 1).
- Frame per byte:
  - 1 start bit (0), then 8 data bits LSB first, then 1 stop bit (1).
  - Each bit is held for exactly CLKS_PER_BIT cycles.
  - The baud counter counts 0..CLKS_PER_BIT-1 and advances the state or bit on the terminal count.
- States and transitions:
  - IDLE -> START on an accepted Send.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA shifts 8 bits; bit index 0..7; after bit 7 -> STOP.
  - STOP -> START with byte_sel=B if byte_sel=A. There is no idle gap: B's start bit follows A's stop bit back to back.
  - STOP -> IDLE if byte_sel=B. In the same transition Done=1 for one cycle and Busy=0.
- Total Busy duration: exactly 20*CLKS_PER_BIT cycles, or 22*CLKS_PER_BIT with PARITY_EN.
- Changes on Aval/Bval while Busy have no effect on the transmitted data, because the snapshot is taken at accept.
- Reset mid-frame aborts immediately. Tx=1 and Busy=0 on the next edge with no Done pulse, and any partial frame is dropped.
- Send held high continuously produces exactly one transmission. Send re-asserted (0 then 1) in the same cycle Done pulses is ignored. It must be released and pressed again after returning to IDLE.
- Tx is driven from a register, so it is glitch-free.

Optional Feature:
- Macro: RESULT_TX_PARITY_EN.
- Defined: an even-parity bit (XOR of the 8 data bits) is inserted between data bit 7 and the stop bit, with a PARITY state between DATA and STOP. Frame is 11 bits and Busy lasts 22*CLKS_PER_BIT cycles.
- Undefined: no parity bit, the PARITY state is not compiled in, frame is 10 bits.

Test Plan:
1. CLKS_PER_BIT=4, Aval=8'h5A, Bval=8'hC3, pulse Send:
   - Tx sequence is 0,0,1,0,1,1,0,1,0,1 then 0,1,1,0,0,0,0,1,1,1, each held for 4 cycles.
   - Busy is high for 80 cycles, then Done pulses once and Tx=1.
2. Hold Send high for 200 cycles with CLKS_PER_BIT=4: exactly one 80-cycle transmission and one Done pulse, no second frame pair.
3. Change Aval from 8'h00 to 8'hFF 10 cycles after accept: the first frame still carries 8'h00 (data bits all 0).
4. Assert Reset=0 for one cycle at cycle 30 of a transmission:
   - Tx=1 and Busy=0 the next cycle; Done never pulses.
   - A new Send then transmits correctly.
5. Pulse Send again at cycle 40 while Busy: it is ignored, and the total transmission is still 80 cycles.
6. With RESULT_TX_PARITY_EN, Aval=8'h07, Bval=8'h03, CLKS_PER_BIT=4:
   - Parity bits are 1 and 0 respectively.
   - Busy lasts 88 cycles.

Source files
------------

// File: rtl/result_serial_tx.sv
// result_serial_tx: bit-serial dump of the final A/B register values.
// On a Send rising edge the module takes a snapshot of Aval and Bval. It then
// sends two back-to-back UART frames (A first, then B) on Tx. Each frame is
// 1 start bit, 8 data bits LSB first and 1 stop bit.
// Optional: define RESULT_TX_PARITY_EN to insert an even-parity bit after the
// data bits. This makes each frame 11 bits long.
module result_serial_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Send,
  input  logic [7:0] Aval,
  input  logic [7:0] Bval,
  output logic       Tx,
  output logic       Busy,
  output logic       Done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef RESULT_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t        state_q;
  logic [CW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic          sel_b_q;
  logic [7:0]    a_q, b_q;
  logic          send_prev_q;
  logic          tx_q, busy_q, done_q;

  logic [7:0] cur_byte;
  logic       baud_last;
  logic       accept;

  assign cur_byte  = sel_b_q ? b_q : a_q;
  assign baud_last = (baud_q == BAUD_LAST);
  // A press during the Done cycle is ignored, so the button must be released
  // and pressed again once the module is idle.
  assign accept    = (state_q == IDLE) && Send && !send_prev_q && !done_q;

  // Frame sequencer with registered line and status outputs.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q     <= IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      sel_b_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      send_prev_q <= 1'b1;  // a button held through reset must not fire
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      send_prev_q <= Send;
      done_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          baud_q <= '0;
          bit_q  <= '0;
          tx_q   <= 1'b1;
          if (accept) begin
            a_q     <= Aval;
            b_q     <= Bval;
            sel_b_q <= 1'b0;
            state_q <= START;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (baud_last) begin
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= cur_byte[0];
            state_q <= DATA;
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
`ifdef RESULT_TX_PARITY_EN
              tx_q    <= ^cur_byte;
              state_q <= PARITY;
`else
              tx_q    <= 1'b1;
              state_q <= STOP;
`endif
            end else begin
              bit_q <= bit_q + 3'd1;
              tx_q  <= cur_byte[bit_q + 3'd1];
            end
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
`ifdef RESULT_TX_PARITY_EN
        PARITY: begin
          if (baud_last) begin
            baud_q  <= '0;
            tx_q    <= 1'b1;
            state_q <= STOP;
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
`endif
        STOP: begin
          if (baud_last) begin
            baud_q <= '0;
            if (!sel_b_q) begin
              // The B start bit directly follows the A stop bit, with no idle gap.
              sel_b_q <= 1'b1;
              tx_q    <= 1'b0;
              state_q <= START;
            end else begin
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Tx   = tx_q;
  assign Busy = busy_q;
  assign Done = done_q;

endmodule

// File: tb/tb_result_serial_tx.sv
// Testbench for result_serial_tx with CLKS_PER_BIT=4. The expected line
// waveform is built from the frame format: start, LSB-first data,
// optional parity, stop.
module tb_result_serial_tx;
  localparam int N = 4;
`ifdef RESULT_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       Send = 1'b0;
  logic [7:0] Aval = 8'h00;
  logic [7:0] Bval = 8'h00;
  logic       Tx, Busy, Done;

  int tests = 0;
  int fails = 0;
  bit exp_q[$];

  result_serial_tx #(.CLKS_PER_BIT(N)) dut (
    .Clk(Clk), .Reset(Reset), .Send(Send), .Aval(Aval), .Bval(Bval),
    .Tx(Tx), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  // Expected bit sequence for the A frame followed by the B frame.
  task automatic build(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] v;
    exp_q.delete();
    for (int f = 0; f < 2; f++) begin
      v = (f == 0) ? a : b;
      exp_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp_q.push_back(v[i]);
`ifdef RESULT_TX_PARITY_EN
      exp_q.push_back(^v);
`endif
      exp_q.push_back(1'b1);
    end
  endtask

  task automatic check_idle(input string name, input logic want_done);
    tests++;
    if (Tx !== 1'b1 || Busy !== 1'b0 || Done !== want_done) begin
      fails++;
      $display("FAIL %s: tx=%b busy=%b done=%b, want tx=1 busy=0 done=%b",
               name, Tx, Busy, Done, want_done);
    end
  endtask

  // Sends one A/B pair and checks every busy cycle, then the Done cycle.
  // Optional side actions: change Aval at cycle chg_at, pulse Send at
  // cycle pulse_at, keep Send held, or press Send during the Done cycle.
  task automatic xmit(input string name, input logic [7:0] a, input logic [7:0] b,
                      input int chg_at, input logic [7:0] chg_val,
                      input int pulse_at, input bit hold, input bit press_done);
    Aval = a; Bval = b;
    build(a, b);
    Send = 1'b1;
    tick;
    if (!hold) Send = 1'b0;
    for (int c = 0; c < 2 * FB * N; c++) begin
      tests++;
      if (Tx !== exp_q[c / N] || Busy !== 1'b1 || Done !== 1'b0) begin
        fails++;
        $display("FAIL %s cyc %0d: tx=%b busy=%b done=%b, want tx=%b busy=1 done=0",
                 name, c, Tx, Busy, Done, exp_q[c / N]);
      end
      if (c == chg_at) Aval = chg_val;
      if (pulse_at >= 0 && c == pulse_at) Send = 1'b1;
      if (pulse_at >= 0 && c == pulse_at + 1) Send = 1'b0;
      tick;
    end
    check_idle({name, " done"}, 1'b1);
    if (press_done) Send = 1'b1;
    tick;
    check_idle({name, " after"}, 1'b0);
  endtask

  task automatic test_reset;
    Send = 1'b1;  // held through reset, must not trigger
    Reset = 1'b0;
    tick; tick;
    check_idle("reset", 1'b0);
    Reset = 1'b1;
    for (int i = 0; i < 10; i++) tick;
    check_idle("held_through_reset", 1'b0);
    Send = 1'b0;
    tick;
  endtask

  task automatic test_basic;
    xmit("basic_5A_C3", 8'h5A, 8'hC3, -1, 8'h00, -1, 1'b0, 1'b0);
    tick;
  endtask

  task automatic test_hold;
    xmit("hold", 8'h96, 8'h3C, -1, 8'h00, -1, 1'b1, 1'b0);
    for (int i = 0; i < 200 - 2 * FB * N - 2; i++) begin
      tick;
      check_idle("hold_no_retrigger", 1'b0);
    end
    Send = 1'b0;
    tick;
  endtask

  task automatic test_snapshot;
    xmit("snapshot", 8'h00, 8'hA5, 10, 8'hFF, -1, 1'b0, 1'b0);
    tick;
  endtask

  task automatic test_mid_reset;
    Aval = 8'h81; Bval = 8'h18;
    build(Aval, Bval);
    Send = 1'b1;
    tick;
    Send = 1'b0;
    for (int c = 0; c <= 30; c++) begin
      tests++;
      if (Tx !== exp_q[c / N] || Busy !== 1'b1) begin
        fails++;
        $display("FAIL mid_reset pre cyc %0d: tx=%b busy=%b, want tx=%b busy=1",
                 c, Tx, Busy, exp_q[c / N]);
      end
      if (c == 30) Reset = 1'b0;
      tick;
    end
    Reset = 1'b1;
    check_idle("mid_reset_abort", 1'b0);
    for (int i = 0; i < 100; i++) begin
      tick;
      tests++;
      if (Done !== 1'b0 || Busy !== 1'b0) begin
        fails++;
        $display("FAIL mid_reset_quiet cyc %0d: busy=%b done=%b, want 0 0", i, Busy, Done);
      end
    end
    xmit("after_reset", 8'h3E, 8'hE3, -1, 8'h00, -1, 1'b0, 1'b0);
    tick;
  endtask

  task automatic test_busy_press;
    xmit("busy_press", 8'h5A, 8'hC3, -1, 8'h00, 40, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick;
      check_idle("busy_press_no_requeue", 1'b0);
    end
  endtask

  task automatic test_done_press;
    xmit("done_press", 8'h11, 8'h22, -1, 8'h00, -1, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick;
      check_idle("done_press_ignored", 1'b0);
    end
    Send = 1'b0;
    tick;
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 6; k++) begin
      xmit("random", 8'($urandom), 8'($urandom), int'($urandom_range(0, 70)),
           8'($urandom), int'($urandom_range(0, 70)), 1'b0, 1'b0);
      tick;
    end
  endtask

`ifdef RESULT_TX_PARITY_EN
  task automatic test_parity;
    xmit("parity_07_03", 8'h07, 8'h03, -1, 8'h00, -1, 1'b0, 1'b0);
    tick;
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_hold;
    test_snapshot;
    test_mid_reset;
    test_busy_press;
    test_done_press;
    test_back_to_back;
`ifdef RESULT_TX_PARITY_EN
    test_parity;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
